// File: rtl/crypt_result_reader.sv
// Snapshots the ciphertext on start and streams it least-significant chunk first over valid/ready.
// First chunk is visible the cycle after start, then one chunk per cycle while ready stays high.
module crypt_result_reader #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] C_ex,
   output logic [CHUNK-1:0] chunk_o,
   output logic             chunk_valid,
   input  logic             chunk_ready,
   output logic             chunk_last,
   output logic             busy,
   output logic             done
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] snap_q, snap_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CHUNK-1:0] chunk_d;
   logic             done_d;

   // In SEND chunk_valid is always 1, so a ready here is a full handshake.
   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (!clear) begin
         state_d = IDLE;
         snap_d  = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = SEND;
                  snap_d  = C_ex;
                  cnt_d   = '0;
               end
            end
            SEND: begin
               if (chunk_ready) begin
                  if (cnt_q == LAST) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      chunk_d = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (cnt_d == CW'(i)) chunk_d = snap_d[i*CHUNK +: CHUNK];
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= IDLE;
         snap_q      <= '0;
         cnt_q       <= '0;
         chunk_o     <= '0;
         chunk_valid <= 1'b0;
         chunk_last  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else if (ena) begin
         state_q     <= state_d;
         snap_q      <= snap_d;
         cnt_q       <= cnt_d;
         chunk_o     <= chunk_d;
         chunk_valid <= (state_d == SEND);
         chunk_last  <= (state_d == SEND) && (cnt_d == LAST);
         busy        <= (state_d == SEND);
         done        <= done_d;
      end
   end
endmodule

// File: doc/crypt_result_reader.md
Name: crypt_result_reader

Overview:
Readout side of the RSA engine's ciphertext register. On a start pulse it snapshots the WIDTH-bit ciphertext value and streams it out in CHUNK-bit pieces, least-significant chunk first, over a valid/ready handshake toward the host-facing output/SPI logic. It decouples the host's read rate from the engine, so the ciphertext register may change as soon as the snapshot is taken.

Parameters:
WIDTH, 8, ciphertext width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits per output transfer; 1 <= CHUNK <= WIDTH.

Ports:
clk  input  1  clock, rising edge.
rstb  input  1  asynchronous active-low reset.
ena  input  1  global clock enable; when 0, all state is frozen.
clear  input  1  active-low synchronous abort; sampled only when ena=1.
start  input  1  capture request; sampled only when ena=1.
C_ex  input  WIDTH  ciphertext register value to be read out.
chunk_o  output  CHUNK  current output chunk.
chunk_valid  output  1  chunk_o holds valid data.
chunk_ready  input  1  consumer accepts chunk_o.
chunk_last  output  1  the current chunk is the final (most-significant) chunk.
busy  output  1  a readout is in progress.
done  output  1  one-cycle pulse after the final chunk is accepted.

Behaviour:
- Reset (rstb=0, asynchronous): state IDLE, snapshot register = 0, chunk counter = 0.
  - Outputs: chunk_o=0, chunk_valid=0, chunk_last=0, busy=0, done=0.
  - Reset asserted mid-readout abandons the transfer; no done pulse is produced.
- NCHUNK = WIDTH/CHUNK. The counter is max(1, clog2(NCHUNK)) bits wide and counts 0..NCHUNK-1 with no wrap past NCHUNK-1.
- All outputs are registered.
  - chunk_o = snapshot[CHUNK*cnt +: CHUNK].
  - chunk_last = chunk_valid and (cnt == NCHUNK-1).
- ena=0: no register updates. Outputs hold their values. start, clear and handshakes are ignored, even if chunk_valid=1 and chunk_ready=1.
- States:
  - IDLE: busy=0, chunk_valid=0.
    - start=1 (with ena=1, clear=1): snapshot <= C_ex, cnt <= 0, go to SEND.
    - Latency: start sampled on edge N, chunk_valid=1 from edge N through N+1's cycle, i.e. valid is visible in the cycle after start.
  - SEND: busy=1, chunk_valid=1.
    - A handshake is chunk_valid & chunk_ready & ena on a rising edge.
    - Handshake with cnt < NCHUNK-1: cnt <= cnt+1. The next chunk is presented in the following cycle, so back-to-back transfers run at one chunk per cycle.
    - Handshake with cnt == NCHUNK-1: go to IDLE, chunk_valid <= 0, busy <= 0, done <= 1 for exactly one cycle.
    - chunk_o and chunk_last are stable while chunk_valid=1 and chunk_ready=0.
- start while busy=1 is ignored. Changes on C_ex during SEND do not affect the output.
- start in the cycle that done=1 (state already IDLE) is accepted normally.
- start and chunk_ready both high in IDLE: capture only; no chunk is consumed.
- clear=0 with ena=1 (any state): go to IDLE, snapshot <= 0, cnt <= 0, chunk_valid <= 0, busy <= 0, done <= 0.
  - clear takes priority over start and over a same-cycle handshake.
  - No done pulse is produced.
- NCHUNK == 1: the first handshake is also the last; chunk_last=1 whenever chunk_valid=1.

Test Plan:
1. WIDTH=8, CHUNK=4, C_ex=0xA5, pulse start, chunk_ready held 1 -> chunk_o=0x5 (chunk_last=0) then 0xA (chunk_last=1) on consecutive cycles; done=1 one cycle later; busy=0.
2. Same capture, chunk_ready=0 for 3 cycles then 1 -> chunk_o stays 0x5 with chunk_valid=1 during the stall; C_ex changed to 0x3C mid-transfer -> outputs still 0x5, 0xA.
3. During SEND, drop ena for 2 cycles with chunk_ready=1 -> cnt, outputs and valid frozen; no chunk is consumed; the transfer resumes when ena=1.
4. clear=0 asserted during the handshake of chunk 0 -> next cycle chunk_valid=0, busy=0, done never pulses; a new start with C_ex=0x42 -> chunks 0x2 then 0x4.
5. Pulse start again while busy -> ignored, original data continues; start in the done cycle with C_ex=0xFF -> second readout 0xF, 0xF.
6. rstb pulled low mid-SEND -> all outputs 0 immediately (asynchronous); after release the block sits in IDLE until start. Also run WIDTH=4, CHUNK=4 with C_ex=0x9 -> a single chunk 0x9 with chunk_last=1, then done.
